// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared constants and the scan FSM state type for the
//                ADC channel scan / averaging block.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

   localparam int NUM_CH   = 8;
   localparam int SAMPLE_W = 12;
   localparam int ADDR_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_ACCUM  = 2'd2,
      ST_EMIT   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_ch_picker.sv
`default_nettype none
// ============================================================================
//  Module      : adc_ch_picker
//  Description : Round-robin next-channel search. Returns the first set mask
//                bit strictly above i_cur, wrapping 7->0; i_cur itself is the
//                last candidate, so a single-channel mask re-selects it.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_ch_picker
   import adc_pkg::*;
(
   input  logic [NUM_CH-1:0] i_mask,
   input  logic [ADDR_W-1:0] i_cur,
   output logic [ADDR_W-1:0] o_next,
   output logic              o_found
);

   logic [ADDR_W-1:0] w_idx;

   // Scan offsets from farthest to nearest so the nearest hit overrides.
   always_comb begin
      o_next  = i_cur;
      o_found = 1'b0;
      w_idx   = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         // ADDR_W-bit addition wraps modulo NUM_CH; offset NUM_CH lands on i_cur
         w_idx = i_cur + ADDR_W'(k);
         if (i_mask[w_idx]) begin
            o_next  = w_idx;
            o_found = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/adc_scan_avg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_avg
//  Description : Scans the enabled ADC channels round-robin, drops the first
//                DISCARD conversions after each channel change, averages
//                2^AVG_LOG2 conversions and presents the result through a
//                one-entry valid/ready output register with a sticky overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_avg
   import adc_pkg::*;
#(
   parameter int AVG_LOG2 = 3,
   parameter int DISCARD  = 1
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [NUM_CH-1:0]   ch_mask,
   input  logic                smp_valid,
   input  logic [SAMPLE_W-1:0] smp_data,
   output logic                ctl_valid,
   output logic [ADDR_W-1:0]   address,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [SAMPLE_W-1:0] res_data,
   output logic [ADDR_W-1:0]   res_ch,
   output logic                overrun,
   input  logic                ovr_clr
);

   localparam int ACC_W = SAMPLE_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int DSC_W = (DISCARD < 1) ? 1 : $clog2(DISCARD + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   state_t              r_state;
   logic                r_ctl_valid;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_cur;
   logic [ACC_W-1:0]    r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic [DSC_W-1:0]    r_dsc;
   logic                r_smp_vld;
   logic [SAMPLE_W-1:0] r_smp_dat;
   logic                r_res_vld;
   logic [SAMPLE_W-1:0] r_res_dat;
   logic [ADDR_W-1:0]   r_res_ch;
   logic                r_ovr;

   logic [ADDR_W-1:0]   w_next;
   logic                w_found;
   logic [SAMPLE_W-1:0] w_avg;
   logic                w_emit;
   logic                w_load;
   logic                w_drop;

   adc_ch_picker u_picker (
      .i_mask  (ch_mask),
      .i_cur   (r_cur),
      .o_next  (w_next),
      .o_found (w_found)
   );

   // Truncating divide by 2^AVG_LOG2: the top SAMPLE_W bits of the accumulator.
   assign w_avg  = r_acc[ACC_W-1:AVG_LOG2];
   assign w_emit = (r_state == ST_EMIT) && en;
   assign w_load = w_emit && (!r_res_vld || res_ready);
   assign w_drop = w_emit && r_res_vld && !res_ready;

   // Register conversions that arrive while accumulating; the FSM consumes them a clk later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_smp_vld <= 1'b0;
         r_smp_dat <= '0;
      end else begin
         r_smp_vld <= smp_valid && en && (r_state == ST_ACCUM);
         if (smp_valid) begin
            r_smp_dat <= smp_data;
         end
      end
   end

   // Scan FSM: channel selection, discard countdown and accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ctl_valid <= 1'b0;
         r_addr      <= '0;
         r_cur       <= ADDR_W'(NUM_CH - 1);   // next search begins at channel 0
         r_acc       <= '0;
         r_cnt       <= '0;
         r_dsc       <= '0;
      end else if (!en) begin
         r_state     <= ST_IDLE;
         r_ctl_valid <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_dsc       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ch_mask != '0) begin
                  r_state     <= ST_SELECT;
                  r_ctl_valid <= 1'b1;
               end
            end
            ST_SELECT: begin
               r_acc <= '0;
               r_cnt <= '0;
               r_dsc <= DSC_W'(DISCARD);
               if (w_found) begin
                  r_addr  <= w_next;
                  r_cur   <= w_next;
                  r_state <= ST_ACCUM;
               end else begin
                  r_state     <= ST_IDLE;
                  r_ctl_valid <= 1'b0;
               end
            end
            ST_ACCUM: begin
               if (r_smp_vld) begin
                  if (r_dsc != '0) begin
                     r_dsc <= r_dsc - DSC_W'(1);
                  end else begin
                     r_acc <= r_acc + ACC_W'(r_smp_dat);
                     r_cnt <= r_cnt + CNT_W'(1);
                     if (r_cnt == CNT_LAST) begin
                        r_state <= ST_EMIT;
                     end
                  end
               end
            end
            ST_EMIT: begin
               r_state <= ST_SELECT;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_ctl_valid <= 1'b0;
            end
         endcase
      end
   end

   // One-entry result register with sticky overrun; a new drop beats ovr_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_vld <= 1'b0;
         r_res_dat <= '0;
         r_res_ch  <= '0;
         r_ovr     <= 1'b0;
      end else begin
         if (w_load) begin
            r_res_vld <= 1'b1;
            r_res_dat <= w_avg;
            r_res_ch  <= r_addr;
         end else if (res_ready) begin
            r_res_vld <= 1'b0;
         end
         if (w_drop) begin
            r_ovr <= 1'b1;
         end else if (ovr_clr) begin
            r_ovr <= 1'b0;
         end
      end
   end

   assign ctl_valid = r_ctl_valid;
   assign address   = r_addr;
   assign res_valid = r_res_vld;
   assign res_data  = r_res_dat;
   assign res_ch    = r_res_ch;
   assign overrun   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_avg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_avg
//  Description : Directed self-checking bench for adc_scan_avg. Expected
//                results are queued as samples are driven and compared when
//                the DUT hands a result over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_avg;
   import adc_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                en;
   logic                en4;
   logic [NUM_CH-1:0]   ch_mask;
   logic                smp_valid;
   logic [SAMPLE_W-1:0] smp_data;
   logic                res_ready;
   logic                rdy4;
   logic                ovr_clr;

   logic                ctl_valid, res_valid, overrun;
   logic [ADDR_W-1:0]   address, res_ch;
   logic [SAMPLE_W-1:0] res_data;

   logic                ctl_valid4, res_valid4, overrun4;
   logic [ADDR_W-1:0]   address4, res_ch4;
   logic [SAMPLE_W-1:0] res_data4;

   typedef struct packed {
      logic [ADDR_W-1:0]   ch;
      logic [SAMPLE_W-1:0] data;
   } res_t;

   res_t        sb[$];
   res_t        exp_r;
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [2:0]  order [5] = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5};

   adc_scan_avg #(.AVG_LOG2(3), .DISCARD(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
      .smp_valid(smp_valid), .smp_data(smp_data),
      .ctl_valid(ctl_valid), .address(address),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_ch(res_ch),
      .overrun(overrun), .ovr_clr(ovr_clr)
   );

   adc_scan_avg #(.AVG_LOG2(4), .DISCARD(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .ch_mask(ch_mask),
      .smp_valid(smp_valid), .smp_data(smp_data),
      .ctl_valid(ctl_valid4), .address(address4),
      .res_valid(res_valid4), .res_ready(rdy4),
      .res_data(res_data4), .res_ch(res_ch4),
      .overrun(overrun4), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [SAMPLE_W-1:0] d);
      smp_valid = 1'b1;
      smp_data  = d;
      tick();
      smp_valid = 1'b0;
   endtask

   task automatic start_scan();
      en = 1'b1;
      tick();
      tick();
   endtask

   task automatic stop_scan();
      en = 1'b0;
      tick();
   endtask

   // One channel visit: one throw-away conversion then eight ramp samples.
   task automatic visit(input logic [2:0] ch, input int base, input int step, input bit push);
      int   sum;
      res_t r;
      sum = 0;
      check("addr_first", address, ch);
      pulse(12'd999);
      for (int i = 0; i < 8; i++) begin
         logic [SAMPLE_W-1:0] d;
         d = SAMPLE_W'(base + step * i);
         sum += int'(d);
         pulse(d);
      end
      check("addr_last", address, ch);
      if (push) begin
         r.ch   = ch;
         r.data = SAMPLE_W'(sum >> 3);
         sb.push_back(r);
      end
   endtask

   // Handshake monitor: every accepted result must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         check("sb_nonempty_at_result", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_r = sb.pop_front();
            check("sb_res_data", res_data, exp_r.data);
            check("sb_res_ch", res_ch, exp_r.ch);
         end
      end
   end

   // Directed sequence
   initial begin
      rst_n = 1'b0; en = 1'b0; en4 = 1'b0; ch_mask = '0; smp_valid = 1'b0;
      smp_data = '0; res_ready = 1'b1; rdy4 = 1'b1; ovr_clr = 1'b0;
      tick();
      tick();
      check("rst_ctl_valid", ctl_valid, 0);
      check("rst_address", address, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_ch", res_ch, 0);
      check("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      tick();

      // Single channel ramp: 999 discarded, mean of 100..114 step 2 is 107
      ch_mask = 8'h01;
      start_scan();
      check("ctl_valid_run", ctl_valid, 1);
      visit(3'd0, 100, 2, 1'b1);
      tick();
      check("rv_after_1clk", res_valid, 0);
      tick();
      check("rv_after_2clk", res_valid, 1);
      check("res_data_107", res_data, 107);
      check("res_ch_0", res_ch, 0);
      tick();
      stop_scan();
      check("ctl_valid_idle", ctl_valid, 0);

      // Round-robin order over channels 2, 5, 7
      ch_mask = 8'b1010_0100;
      start_scan();
      for (int v = 0; v < 5; v++) begin
         visit(order[v], 300 + 10 * int'(order[v]), 0, 1'b1);
         tick(); tick(); tick();
      end
      stop_scan();

      // Back-pressure: hold first result, drop the next, set beats clear
      res_ready = 1'b0;
      ch_mask   = 8'h08;
      start_scan();
      visit(3'd3, 200, 0, 1'b1);
      tick(); tick(); tick();
      check("ovr_before_drop", overrun, 0);
      visit(3'd3, 300, 0, 1'b0);
      tick(); tick();
      check("ovr_after_drop", overrun, 1);
      check("held_valid", res_valid, 1);
      check("held_data", res_data, 200);
      check("held_ch", res_ch, 3);
      tick();
      visit(3'd3, 400, 0, 1'b0);
      tick();
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check("ovr_set_wins", overrun, 1);
      check("held_data_2", res_data, 200);
      tick();
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check("ovr_cleared", overrun, 0);
      res_ready = 1'b1;
      tick();
      check("rv_after_accept", res_valid, 0);
      stop_scan();

      // Abort after four samples: nothing emitted, next visit starts afresh
      ch_mask = 8'h10;
      start_scan();
      check("abort_addr", address, 4);
      for (int i = 0; i < 5; i++) pulse(12'd4000);
      stop_scan();
      check("abort_ctl_valid", ctl_valid, 0);
      for (int i = 0; i < 10; i++) tick();
      check("abort_no_result", res_valid, 0);
      start_scan();
      visit(3'd4, 10, 1, 1'b1);
      tick(); tick(); tick();
      stop_scan();

      // Asynchronous reset with a held result and a pending accumulation
      res_ready = 1'b0;
      ch_mask   = 8'h23;
      start_scan();
      visit(3'd5, 50, 0, 1'b0);
      tick(); tick(); tick();
      visit(3'd0, 60, 0, 1'b0);
      tick(); tick(); tick();
      check("pre_rst_addr", address, 1);
      check("pre_rst_valid", res_valid, 1);
      check("pre_rst_ovr", overrun, 1);
      check("pre_rst_data", res_data, 50);
      for (int i = 0; i < 3; i++) pulse(12'd20);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ctl_valid", ctl_valid, 0);
      check("arst_address", address, 0);
      check("arst_res_valid", res_valid, 0);
      check("arst_res_data", res_data, 0);
      check("arst_res_ch", res_ch, 0);
      check("arst_overrun", overrun, 0);
      tick();
      rst_n     = 1'b1;
      res_ready = 1'b1;
      start_scan();
      visit(3'd0, 70, 0, 1'b1);
      tick(); tick(); tick();
      stop_scan();

      // Full-scale samples with 16-sample averaging
      ch_mask = 8'h80;
      en4     = 1'b1;
      tick();
      tick();
      check("avg16_addr", address4, 7);
      for (int i = 0; i < 17; i++) pulse(12'd4095);
      tick();
      check("avg16_rv_1clk", res_valid4, 0);
      tick();
      check("avg16_rv_2clk", res_valid4, 1);
      check("avg16_data", res_data4, 4095);
      check("avg16_ch", res_ch4, 7);
      en4 = 1'b0;
      tick();

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adc_scan_avg.md
ADC_SCAN_AVG -- requirements
Module: adc_scan_avg

Interface
REQ-001 Parameter AVG_LOG2, default 3, means log2 of the samples averaged per channel visit (range 0..4).
REQ-002 Parameter DISCARD, default 1, means the number of samples dropped after each channel change (ADC pipeline latency).
REQ-003 Port clk  in  1  is the single clock; the block has one clock, and every flop is clocked on its rising edge.
REQ-004 Port rst_n  in  1  is the reset, asynchronous and active-low.
REQ-005 Port en  in  1  is the scan enable.
REQ-006 Port ch_mask  in  8  selects the enabled channels IN0..IN7 (bit i = channel i).
REQ-007 Port smp_valid  in  1  is a one-clk pulse marking a new conversion from the capture stage.
REQ-008 Port smp_data  in  12  is the conversion result, valid when smp_valid=1.
REQ-009 Port ctl_valid  out  1  is the run enable to the capture stage.
REQ-010 Port address  out  3  is the channel address to the capture stage.
REQ-011 Port res_valid  out  1  marks the averaged result as valid.
REQ-012 Port res_ready  in  1  is the consumer accepting the result.
REQ-013 Port res_data  out  12  is the averaged sample.
REQ-014 Port res_ch  out  3  is the channel of res_data.
REQ-015 Port overrun  out  1  is a sticky flag: a result was dropped.
REQ-016 Port ovr_clr  in  1  clears overrun.

Function
REQ-017 The FSM SHALL have states IDLE, SELECT, ACCUM and EMIT.
- IDLE->SELECT when en=1 and ch_mask!=0.
- SELECT->ACCUM after one clk.
- ACCUM->EMIT on acceptance of the 2^AVG_LOG2-th sample.
- EMIT->SELECT after one clk.
REQ-018 In SELECT, the block SHALL load address with the next set ch_mask bit strictly above the current channel, searching round-robin with wrap 7->0; the first SELECT after reset starts the search at channel 0 inclusive.
REQ-019 In SELECT, the block SHALL clear the accumulator and sample counter and load the discard counter with DISCARD.
REQ-020 In ACCUM, each smp_valid SHALL decrement the discard counter while it is nonzero; otherwise it adds smp_data to the accumulator (width 12+AVG_LOG2, no overflow possible) and increments the counter.
REQ-021 smp_valid in IDLE, SELECT or EMIT SHALL be ignored.
REQ-022 In EMIT, the result SHALL be accumulator >> AVG_LOG2 (truncating), tagged with the current address.
REQ-023 The block SHALL have a one-entry output register. EMIT loads it when res_valid=0, or when res_valid=1 and res_ready=1 in the same clk. Otherwise the new result is dropped, overrun is set, and the held result is unchanged.
REQ-024 res_valid SHALL rise on the 2nd clk edge after the edge that captured the final sample, and stay high with res_data/res_ch stable until a clk with res_ready=1.
REQ-025 ctl_valid SHALL be 1 in every state except IDLE.
REQ-026 address SHALL change only on SELECT entry; it is stable throughout ACCUM.
REQ-027 ch_mask changes SHALL take effect at the next SELECT only. If ch_mask==0 at SELECT, the FSM returns to IDLE without changing address.
REQ-028 en=0 in any state SHALL force IDLE on the next edge and discard the partial accumulation; the output register and overrun are retained.
REQ-029 overrun set and ovr_clr in the same clk SHALL leave overrun=1 (set wins).

Reset
REQ-030 With rst_n=0, the block SHALL go to state IDLE with all of these at 0: ctl_valid, address, res_valid, res_data, res_ch, overrun, accumulator and counters. The current-channel pointer is set so the next search starts at channel 0.
REQ-031 Reset assertion mid-ACCUM or with res_valid=1 SHALL drop all pending data; there is no handshake completion.

Structure
REQ-032 Package adc_pkg SHALL hold the state enum typedef, NUM_CH=8, SAMPLE_W=12 and ADDR_W=3.
REQ-033 The round-robin next-channel search SHALL be the combinational sub-module adc_ch_picker (inputs mask and current channel; outputs next channel and found).

Verification
REQ-034 Scenario: AVG_LOG2=3, DISCARD=1, ch_mask=8'h01, smp_data sequence 999 then 100,102,...,114, res_ready=1 -> res_data=107, res_ch=0, res_valid high exactly 2 clks after the 9th pulse.
REQ-035 Scenario: ch_mask=8'b1010_0100, constant samples -> res_ch order 2,5,7,2,5; address constant during each ACCUM.
REQ-036 Scenario: res_ready=0 for two full result periods -> first result held stable, second dropped, overrun=1. Then ovr_clr together with a fresh drop -> overrun stays 1.
REQ-037 Scenario: en deasserted after 4 of 8 samples, then reasserted -> no result emitted, the next visit re-discards and averages 8 fresh samples.
REQ-038 Scenario: rst_n low mid-ACCUM with res_valid=1 -> all outputs 0 asynchronously; after release, the first address is the lowest set mask bit.
REQ-039 Scenario: all samples 4095, AVG_LOG2=4 -> res_data=4095, with no accumulator wrap.
